prom_arbiter: RTL

- Shares the single-port 8K x 16 program ROM (13-bit address, 16-bit data, synchronous read) between two requesters.
  - Fetch port: CPU instruction fetch.
  - Data port: constant loads and the boot-time RAM copier.
- Arbitrates per cycle, drives the ROM enables and address, tracks in-flight reads, and routes each returned word to the requester that issued it.
- Sits between the CPU core / loader and the ROM primitive wrapper.

---
 rtl/prom_pkg.sv | 17 +
 rtl/prom_arbiter_if.sv | 41 ++++
 rtl/prom_tag_pipe.sv | 27 ++
 rtl/prom_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/prom_pkg.sv
// Shared types and constants for the program-ROM arbiter.
// A tag records which requester owns each in-flight ROM read.
package prom_pkg;

  localparam int AW_DEFAULT = 13;
  localparam int DW_DEFAULT = 16;
  localparam int STARVE_W   = 4;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } prom_tag_t;

endpackage

// File: rtl/prom_arbiter_if.sv
// Requester and ROM-side signal bundle of the program-ROM arbiter.
// Handshake: a read is accepted in any cycle where *_req and *_gnt are both high;
// *_valid is a one-cycle pulse with no back-pressure, *_data holds until the next pulse.
interface prom_arbiter_if #(
  parameter int AW = 13,
  parameter int DW = 16
);
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_gnt;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;

  logic          dport_req;
  logic [AW-1:0] dport_addr;
  logic          dport_gnt;
  logic          dport_valid;
  logic [DW-1:0] dport_data;

  logic [AW-1:0] rom_ad;
  logic          rom_ce;
  logic          rom_oce;
  logic          rom_reset;
  logic [DW-1:0] rom_dout;

  logic [3:0]    dbg_starve_cnt;

  modport slave (
    input  fetch_req, fetch_addr, dport_req, dport_addr, rom_dout,
    output fetch_gnt, fetch_valid, fetch_data,
    output dport_gnt, dport_valid, dport_data,
    output rom_ad, rom_ce, rom_oce, rom_reset, dbg_starve_cnt
  );

  modport master (
    output fetch_req, fetch_addr, dport_req, dport_addr, rom_dout,
    input  fetch_gnt, fetch_valid, fetch_data,
    input  dport_gnt, dport_valid, dport_data,
    input  rom_ad, rom_ce, rom_oce, rom_reset, dbg_starve_cnt
  );
endinterface

// File: rtl/prom_tag_pipe.sv
// Shift register of {valid, port} tags tracking ROM reads in flight.
// Depth equals the ROM read latency so the last stage lines up with rom_dout.
module prom_tag_pipe
  import prom_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  prom_tag_t tag_i,
  output prom_tag_t tag_o
);

  prom_tag_t stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/prom_arbiter.sv
// Shares the single-port program ROM between CPU fetch and the data port.
// Fetch has priority, but the data port is forced in after MAX_STARVE fetch wins.
module prom_arbiter
  import prom_pkg::*;
#(
  parameter int ROM_LATENCY = 1,
  parameter int MAX_STARVE  = 4,
  parameter int AW          = AW_DEFAULT,
  parameter int DW          = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  prom_arbiter_if.slave   bus
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);

  logic                rom_reset_q;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [AW-1:0]       last_ad_q, rom_ad_d;
  logic                fetch_gnt, dport_gnt, starve_hit;
  prom_tag_t           tag_in, tag_out;
  logic                fetch_valid_q, dport_valid_q;
  logic [DW-1:0]       fetch_data_q, dport_data_q;

  // Grants are blocked while the ROM itself is still held in reset.
  always_comb begin
    starve_hit = bus.dport_req && (starve_q == STARVE_MAX);
    fetch_gnt  = !rom_reset_q && bus.fetch_req && !starve_hit;
    dport_gnt  = !rom_reset_q && bus.dport_req && !fetch_gnt;
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.dport_req || dport_gnt) begin
      starve_d = '0;
    end else if (fetch_gnt && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    rom_ad_d = last_ad_q;
    if (fetch_gnt) begin
      rom_ad_d = bus.fetch_addr;
    end else if (dport_gnt) begin
      rom_ad_d = bus.dport_addr;
    end
  end

  always_comb begin
    tag_in.valid = fetch_gnt || dport_gnt;
    tag_in.port  = dport_gnt ? PORT_DATA : PORT_FETCH;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_reset_q <= 1'b1;
      starve_q    <= '0;
      last_ad_q   <= '0;
    end else begin
      rom_reset_q <= 1'b0;
      starve_q    <= starve_d;
      last_ad_q   <= rom_ad_d;
    end
  end

  prom_tag_pipe #(
    .DEPTH (ROM_LATENCY)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (reset_n),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  // The last tag stage is aligned with valid rom_dout; capture it for its owner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_valid_q <= 1'b0;
      dport_valid_q <= 1'b0;
      fetch_data_q  <= '0;
      dport_data_q  <= '0;
    end else begin
      fetch_valid_q <= tag_out.valid && (tag_out.port == PORT_FETCH);
      dport_valid_q <= tag_out.valid && (tag_out.port == PORT_DATA);
      if (tag_out.valid && (tag_out.port == PORT_FETCH)) fetch_data_q <= bus.rom_dout;
      if (tag_out.valid && (tag_out.port == PORT_DATA))  dport_data_q <= bus.rom_dout;
    end
  end

  assign bus.fetch_gnt      = fetch_gnt;
  assign bus.dport_gnt      = dport_gnt;
  assign bus.fetch_valid    = fetch_valid_q;
  assign bus.dport_valid    = dport_valid_q;
  assign bus.fetch_data     = fetch_data_q;
  assign bus.dport_data     = dport_data_q;
  assign bus.rom_ad         = rom_ad_d;
  assign bus.rom_ce         = fetch_gnt || dport_gnt;
  assign bus.rom_oce        = 1'b1;
  assign bus.rom_reset      = rom_reset_q;
  assign bus.dbg_starve_cnt = starve_q;

endmodule
